// File: rtl/tx_pkg.sv
// Shared encodings and carrier timing helpers for the transmit burst generator.
package tx_pkg;

    localparam logic [1:0] FREQ_8M = 2'b11;
    localparam logic [1:0] FREQ_4M = 2'b10;
    localparam logic [1:0] FREQ_2M = 2'b01;

    typedef enum logic [1:0] {IDLE, TX, DELAY, GATE} state_t;

    // Half carrier period in clocks; code 00 falls back to 8 MHz.
    function automatic logic [5:0] half_period(input logic [1:0] freq_sel);
        case (freq_sel)
            FREQ_8M: half_period = 6'd4;
            FREQ_4M: half_period = 6'd8;
            FREQ_2M: half_period = 6'd16;
            default: half_period = 6'd4;
        endcase
    endfunction

endpackage

// File: rtl/carrier_nco.sv
// Carrier period counter: free-runs while run is high and derives the
// 8-step quadrature rotation index from the position within the period.
module carrier_nco
    import tx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] freqSel,
    output logic [4:0] cnt,
    output logic [2:0] phase,
    output logic       periodEnd
);

    logic [5:0] last;

    assign last      = (half_period(freqSel) << 1) - 6'd1;
    assign periodEnd = run && ({1'b0, cnt} == last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || periodEnd) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 5'd1;
        end
    end

    // phase = cnt / (H/4), with H/4 = 1, 2 or 4
    always_comb begin
        case (freqSel)
            FREQ_4M: phase = cnt[3:1];
            FREQ_2M: phase = cnt[4:2];
            default: phase = cnt[2:0];
        endcase
    end

endmodule

// File: rtl/tx_burst_gen.sv
// Pulser burst generator: TX burst, receive delay, then a phase-coherent
// receive gate for the I/Q demodulator. All outputs are registered.
module tx_burst_gen
    import tx_pkg::*;
#(
    parameter int unsigned CYC_W = 5,
    parameter int unsigned TIM_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       freqSel,
    input  logic             start,
    input  logic [CYC_W-1:0] burstCycles,
    input  logic [TIM_W-1:0] rxDelay,
    input  logic [TIM_W-1:0] gateLength,
    output logic             busy,
    output logic             txP,
    output logic             txN,
    output logic             gate,
    output logic             demodReset,
    output logic [2:0]       phase,
    output logic             done
);

    state_t           state_q;
    logic [1:0]       freq_q;
    logic [CYC_W-1:0] cyc_q;
    logic [TIM_W-1:0] rxd_q;
    logic [TIM_W-1:0] gl_q;
    logic [TIM_W-1:0] dly_q;
    logic [TIM_W-1:0] gcnt_q;
    logic             fin_q;

    logic [4:0] cnt;
    logic [2:0] nco_phase;
    logic       period_end;
    logic [5:0] hp;
    logic [5:0] per;
    logic [5:0] cnt_ext;

    carrier_nco u_nco (
        .clk       (clk),
        .reset     (reset),
        .run       (state_q != IDLE),
        .freqSel   (freq_q),
        .cnt       (cnt),
        .phase     (nco_phase),
        .periodEnd (period_end)
    );

    assign hp      = half_period(freq_q);
    assign per     = hp << 1;
    assign cnt_ext = {1'b0, cnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            freq_q     <= '0;
            cyc_q      <= '0;
            rxd_q      <= '0;
            gl_q       <= '0;
            dly_q      <= '0;
            gcnt_q     <= '0;
            fin_q      <= 1'b0;
            busy       <= 1'b0;
            txP        <= 1'b0;
            txN        <= 1'b0;
            gate       <= 1'b0;
            demodReset <= 1'b0;
            phase      <= '0;
            done       <= 1'b0;
        end else if (state_q != IDLE && !enable) begin
            // Abort: outputs clear on the same edge, no done and no demodReset.
            state_q    <= IDLE;
            fin_q      <= 1'b0;
            busy       <= 1'b0;
            txP        <= 1'b0;
            txN        <= 1'b0;
            gate       <= 1'b0;
            demodReset <= 1'b0;
            phase      <= '0;
            done       <= 1'b0;
        end else begin
            busy       <= state_q != IDLE;
            txP        <= (state_q == TX) && (cnt_ext <= hp - 6'd2);
            txN        <= (state_q == TX) && (cnt_ext >= hp) && (cnt_ext <= per - 6'd2);
            gate       <= state_q == GATE;
            demodReset <= (state_q == DELAY) && (dly_q == TIM_W'(1));
            phase      <= (state_q != IDLE) ? nco_phase : 3'd0;
            done       <= (state_q == IDLE) && fin_q;
            fin_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start && enable) begin
                        state_q <= TX;
                        freq_q  <= freqSel;
                        cyc_q   <= (burstCycles == '0) ? CYC_W'(1) : burstCycles;
                        rxd_q   <= (rxDelay == '0) ? TIM_W'(1) : rxDelay;
                        gl_q    <= gateLength;
                    end
                end
                TX: begin
                    if (period_end) begin
                        if (cyc_q == CYC_W'(1)) begin
                            state_q <= DELAY;
                            dly_q   <= rxd_q;
                        end else begin
                            cyc_q <= cyc_q - CYC_W'(1);
                        end
                    end
                end
                DELAY: begin
                    if (dly_q == TIM_W'(1)) begin
                        if (gl_q == '0) begin
                            state_q <= IDLE;
                            fin_q   <= 1'b1;
                        end else begin
                            state_q <= GATE;
                            gcnt_q  <= gl_q;
                        end
                    end else begin
                        dly_q <= dly_q - TIM_W'(1);
                    end
                end
                GATE: begin
                    if (gcnt_q == TIM_W'(1)) begin
                        state_q <= IDLE;
                        fin_q   <= 1'b1;
                    end else begin
                        gcnt_q <= gcnt_q - TIM_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_burst_gen.sv
// Scoreboard bench for tx_burst_gen: per-cycle expected output vectors are
// derived from the burst timing formulas and compared one clock at a time.
module tb_tx_burst_gen;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  freqSel;
    logic        start;
    logic [4:0]  burstCycles;
    logic [15:0] rxDelay;
    logic [15:0] gateLength;
    logic        busy, txP, txN, gate, demodReset, done;
    logic [2:0]  phase;
    logic [8:0]  act;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int done_ref;
    logic [8:0] exp_q[$];

    tx_burst_gen dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .freqSel     (freqSel),
        .start       (start),
        .burstCycles (burstCycles),
        .rxDelay     (rxDelay),
        .gateLength  (gateLength),
        .busy        (busy),
        .txP         (txP),
        .txN         (txN),
        .gate        (gate),
        .demodReset  (demodReset),
        .phase       (phase),
        .done        (done)
    );

    assign act = {busy, txP, txN, gate, demodReset, phase, done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int half_of(input logic [1:0] f);
        if (f == 2'b10) return 8;
        if (f == 2'b01) return 16;
        return 4;
    endfunction

    // Vector {busy,txP,txN,gate,demodReset,phase,done} seen after edge E_k (start sampled at E0).
    function automatic logic [8:0] exp_vec(input int h, input int bc, input int rxd, input int gl,
                                           input int k, input int abort_k);
        int t, per, txlen, d, busy_end, c;
        logic b, p, n, g, dr, dn;
        logic [2:0] ph;
        if (k == 0 || (abort_k != 0 && k >= abort_k)) return 9'd0;
        t        = k - 1;
        per      = 2 * h;
        txlen    = ((bc == 0) ? 1 : bc) * per;
        d        = (rxd == 0) ? 1 : rxd;
        busy_end = txlen + d + gl;
        {b, p, n, g, dr, dn} = 6'b0;
        ph = 3'd0;
        if (t >= busy_end) begin
            dn = (t == busy_end);
        end else begin
            b  = 1'b1;
            c  = t % per;
            ph = 3'(c / (h / 4));
            if (t < txlen) begin
                p = (c <= h - 2);
                n = (c >= h) && (c <= per - 2);
            end else if (t < txlen + d) begin
                dr = (t == txlen + d - 1);
            end else begin
                g = 1'b1;
            end
        end
        return {b, p, n, g, dr, ph, dn};
    endfunction

    // Called at a negedge; returns at the negedge after the done edge.
    task automatic run_burst(input logic [1:0] f, input int bc, input int rxd, input int gl,
                             input bit pert, input int abort_k);
        int h, n_end;
        h     = half_of(f);
        n_end = ((bc == 0) ? 1 : bc) * 2 * h + ((rxd == 0) ? 1 : rxd) + gl + 1;
        freqSel     = f;
        burstCycles = 5'(bc);
        rxDelay     = 16'(rxd);
        gateLength  = 16'(gl);
        enable      = 1'b1;
        start       = 1'b1;
        for (int k = 0; k <= n_end; k++) exp_q.push_back(exp_vec(h, bc, rxd, gl, k, abort_k));
        for (int k = 0; k <= n_end; k++) begin
            @(negedge clk);
            start = pert && (k == 2);
            if (pert && k == 2) begin
                freqSel     = 2'b01;
                rxDelay     = 16'd100;
                gateLength  = 16'd1;
                burstCycles = 5'd9;
            end
            enable = !(abort_k != 0 && k == abort_k - 1);
        end
    endtask

    // Scoreboard consumer.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("cycle", 32'(act), 32'(e));
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; start = 1'b0; freqSel = 2'b00;
        burstCycles = '0; rxDelay = '0; gateLength = '0;
        repeat (2) @(posedge clk);
        #1 check_eq("reset_outputs", 32'(act), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 8 MHz reference burst, then a 2 MHz burst started while done is high.
        done_ref = done_cnt;
        run_burst(2'b11, 2, 10, 20, 1'b0, 0);
        run_burst(2'b01, 1, 2, 3, 1'b0, 0);
        repeat (3) @(negedge clk);
        check_eq("done_count_chain", 32'(done_cnt - done_ref), 32'd2);

        // Degenerate zero lengths at 4 MHz.
        run_burst(2'b10, 0, 0, 0, 1'b0, 0);
        repeat (3) @(negedge clk);

        // Extra start and input changes mid-burst must be ignored.
        done_ref = done_cnt;
        run_burst(2'b00, 3, 5, 4, 1'b1, 0);
        repeat (3) @(negedge clk);
        check_eq("done_count_ignore", 32'(done_cnt - done_ref), 32'd1);

        // Abort during GATE, then a normal run after re-enable.
        done_ref = done_cnt;
        run_burst(2'b11, 1, 3, 10, 1'b0, 15);
        repeat (3) @(negedge clk);
        check_eq("done_count_abort", 32'(done_cnt - done_ref), 32'd0);
        run_burst(2'b10, 1, 1, 2, 1'b0, 0);
        repeat (3) @(negedge clk);

        // start ignored while enable is low.
        enable = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("no_start_disabled", 32'(busy), 32'd0);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while txP is high.
        freqSel = 2'b11; burstCycles = 5'd2; rxDelay = 16'd4; gateLength = 16'd4;
        enable = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 check_eq("txp_before_reset", 32'(txP), 32'd1);
        #2 reset = 1'b1;
        #1 check_eq("async_reset_outputs", 32'(act), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check_eq("idle_after_reset", 32'(act), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_burst_gen.md
Name: tx_burst_gen

Overview:
Transmit-side counterpart of the Doppler I/Q demodulator. On a start request it drives the transducer pulser with a bipolar burst at the selected carrier frequency. It then waits a programmable receive delay and opens a phase-coherent receive gate for the demodulator. It also supplies the demodulator with an accumulator-reset pulse and the 3-bit quadrature table rotation index.

Parameters:
CYC_W, 5, width of burstCycles
TIM_W, 16, width of rxDelay / gateLength counters

Ports:
clk  in  1  system clock (64 MHz nominal)
reset  in  1  asynchronous, active-high
enable  in  1  arm; low forces abort to IDLE
freqSel  in  2  11=8 MHz, 10=4 MHz, 01=2 MHz, 00=8 MHz
start  in  1  burst request, sampled in IDLE only
burstCycles  in  CYC_W  carrier periods per burst (0 treated as 1)
rxDelay  in  TIM_W  clocks from burst end to gate open
gateLength  in  TIM_W  clocks gate is open
busy  out  1  high in every state except IDLE
txP  out  1  positive pulser drive
txN  out  1  negative pulser drive
gate  out  1  demodulator enable window
demodReset  out  1  one-clock accumulator clear
phase  out  3  quadrature rotation index, 8 steps per carrier period
done  out  1  one-clock pulse at gate close

Behaviour:
- Reset and clocking: one clock, clk. Reset is asynchronous, active-high.
- Reset values: state=IDLE, all outputs 0, counters 0.
- All outputs are registered.
- Half-period H: 4 clocks for 8 MHz, 8 for 4 MHz, 16 for 2 MHz; the period is 2H.
- Latching: freqSel, burstCycles, rxDelay and gateLength are latched on the accepted start. Input changes while busy are ignored.
- Start latency: if start is sampled high at edge E0 in IDLE with enable=1, txP=1 and busy=1 are visible from E1.
- Carrier counter cnt runs 0..2H-1 and wraps.
  - txP=1 for cnt 0..H-2.
  - txN=1 for cnt H..2H-2.
  - Both are 0 at cnt H-1 and 2H-1 (one dead clock per edge).
  - txP and txN are never high together, under any condition.
- phase = cnt / (H/4). It rotates continuously from burst start through the end of GATE, keeping the receive reference coherent with the transmit carrier. phase=0 in IDLE.
- States:
  - IDLE -> TX on start & enable.
  - TX runs burstCycles full periods, then -> DELAY. txP/txN are 0 outside TX.
  - DELAY lasts max(rxDelay,1) clocks. demodReset=1 on its last clock only. Then -> GATE if gateLength≠0, else -> IDLE with done.
  - GATE: gate=1 for exactly gateLength clocks, then -> IDLE.
- done=1 for one clock on the first IDLE cycle after GATE (or after DELAY when gateLength=0).
- Start while busy is ignored; it is not queued.
- start asserted in the same cycle done is high (already IDLE) is accepted.
- enable=0 in any non-IDLE state: next edge -> IDLE, all outputs 0, no done, no demodReset.
- Asynchronous reset mid-burst: txP/txN drop immediately, with no dead-time guarantee required beyond both low.
- Counter arithmetic is unsigned and must not wrap: DELAY and GATE counters are TIM_W bits and count down to 1.

Decomposition:
- Package tx_pkg: freqSel encodings (FREQ_8M=2'b11, FREQ_4M=2'b10, FREQ_2M=2'b01), state enum {IDLE, TX, DELAY, GATE}, and a function returning the half-period for a freqSel value.
- Sub-module carrier_nco: inputs clk, reset, run, freqSel (latched); outputs cnt, phase, periodEnd. Shared by the TX and GATE phase tracking.
- The top level holds the FSM and the delay/gate counters.

Test Plan:
- 8 MHz, burstCycles=2, rxDelay=10, gateLength=20, start at E0:
  - txP high E1–E3, low E4, txN high E5–E7; the period repeats once.
  - demodReset at E26, gate high E27–E46, done at E47.
  - busy low at E47.
- 2 MHz, burstCycles=1: txP high 15 clocks, dead 1, txN high 15, dead 1.
  - phase increments every 4 clocks, 0..7.
- burstCycles=0, rxDelay=0, gateLength=0 at 4 MHz: exactly one period, one DELAY clock with demodReset, then done; gate never asserts.
- Second start pulse mid-TX and changes to freqSel/rxDelay mid-burst: no effect on timing; done count = 1.
- enable deasserted during GATE: gate and busy drop next edge, no done. A new start after re-enable runs normally.
- Asynchronous reset during TX with txP=1: txP, txN, busy and phase all 0 before the next clk edge; state IDLE afterwards.
